// File: rtl/jk_bank_sched_if.sv
// Requester/response bus for jk_bank_sched: per-requester valid/ready/op/mask
// plus the shared response channel.
interface jk_bank_sched_if #(
   parameter int unsigned W    = 4,
   parameter int unsigned NREQ = 3,
   parameter int unsigned IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [2*NREQ-1:0] req_op;
   logic [W*NREQ-1:0] req_mask;
   logic              rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [W-1:0]      rsp_q;

   modport master (
      output req_valid, req_op, req_mask,
      input  req_ready, rsp_valid, rsp_id, rsp_q
   );

   modport slave (
      input  req_valid, req_op, req_mask,
      output req_ready, rsp_valid, rsp_id, rsp_q
   );
endinterface

// File: rtl/jk_bank_sched.sv
// Round-robin scheduler sharing one bank of JK flip-flops between requesters;
// clears the bank on reset, applies one JK command per grant, returns the new q.
module jk_bank_sched #(
   parameter int unsigned W    = 4,
   parameter int unsigned NREQ = 3,
   parameter int unsigned IDW  = 2
) (
   input  logic         clk,
   input  logic         rst,
   jk_bank_sched_if.slave bus,
   output logic [W-1:0] j_out,
   output logic [W-1:0] k_out,
   input  logic [W-1:0] q_in,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_INIT    = 2'd0,
      S_IDLE    = 2'd1,
      S_APPLY   = 2'd2,
      S_CAPTURE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [IDW-1:0]  r_ptr;
   logic [1:0]      r_op;
   logic [W-1:0]    r_mask;
   logic [IDW-1:0]  r_id;
   logic            r_rsp_valid;
   logic [IDW-1:0]  r_rsp_id;
   logic [W-1:0]    r_rsp_q;

   logic            w_lo_any;
   logic [IDW-1:0]  w_lo_id;
   logic            w_hi_any;
   logic [IDW-1:0]  w_hi_id;
   logic            w_gnt_any;
   logic [IDW-1:0]  w_gnt_id;
   logic [1:0]      w_gnt_op;
   logic [W-1:0]    w_gnt_mask;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [NREQ-1:0] w_ready;
   logic            w_accept;

   // Lowest valid index at/after the pointer wins; otherwise wrap to lowest overall.
   always_comb begin
      w_lo_any   = 1'b0;
      w_lo_id    = '0;
      w_hi_any   = 1'b0;
      w_hi_id    = '0;
      w_gnt_op   = '0;
      w_gnt_mask = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            w_lo_any = 1'b1;
            w_lo_id  = IDW'(i);
            if (IDW'(i) >= r_ptr) begin
               w_hi_any = 1'b1;
               w_hi_id  = IDW'(i);
            end
         end
      end
      w_gnt_any = w_lo_any;
      w_gnt_id  = w_hi_any ? w_hi_id : w_lo_id;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_id == IDW'(i)) begin
            w_gnt_op   = bus.req_op[2*i +: 2];
            w_gnt_mask = bus.req_mask[W*i +: W];
         end
      end
      w_ptr_nxt = (32'(w_gnt_id) == NREQ - 1) ? '0 : w_gnt_id + IDW'(1);
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_INIT;
      else     r_state <= w_state_nxt;
   end

   // Next state and bank/handshake decode
   always_comb begin
      w_state_nxt = r_state;
      j_out       = '0;
      k_out       = '0;
      w_ready     = '0;
      busy        = 1'b1;
      unique case (r_state)
         S_INIT: begin
            k_out       = '1;
            w_state_nxt = S_IDLE;
         end
         S_IDLE: begin
            busy = 1'b0;
            if (w_gnt_any) begin
               for (int i = 0; i < NREQ; i++) begin
                  if (w_gnt_id == IDW'(i)) w_ready[i] = 1'b1;
               end
               w_state_nxt = S_APPLY;
            end
         end
         S_APPLY: begin
            j_out       = r_mask & {W{r_op[1]}};
            k_out       = r_mask & {W{r_op[0]}};
            w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   assign w_accept = (r_state == S_IDLE) && |(bus.req_valid & w_ready);

   // Command latch, rr pointer and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr       <= '0;
         r_op        <= '0;
         r_mask      <= '0;
         r_id        <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_q     <= '0;
      end else begin
         r_rsp_valid <= (r_state == S_CAPTURE);
         if (r_state == S_CAPTURE) begin
            r_rsp_q  <= q_in;
            r_rsp_id <= r_id;
         end
         if (w_accept) begin
            r_op   <= w_gnt_op;
            r_mask <= w_gnt_mask;
            r_id   <= w_gnt_id;
            r_ptr  <= w_ptr_nxt;
         end
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_id    = r_rsp_id;
   assign bus.rsp_q     = r_rsp_q;

endmodule
